// File: rtl/cache_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : cache_bus_pkg
// Brief   : Shared command encodings and bus widths for the CPU/cache/RAM buses.
// Rev     : 1.0  initial release
// ============================================================================
package cache_bus_pkg;

  localparam int ADDR1_BUS_SIZE    = 15;
  localparam int DATA1_BUS_SIZE    = 16;
  localparam int CTR1_BUS_SIZE     = 4;
  localparam int ADDR2_BUS_SIZE    = 15;
  localparam int DATA2_BUS_SIZE    = 16;
  localparam int CTR2_BUS_SIZE     = 2;
  localparam int CACHE_OFFSET_SIZE = 5;
  localparam int CACHE_SET_SIZE    = 5;
  localparam int CACHE_TAG_SIZE    = 10;
  localparam int CPU_CMD_SIZE      = 3;
  localparam int CPU_ADDR_SIZE     = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
  localparam int CPU_DATA_SIZE     = 32;

  typedef enum logic [2:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_WRITE32         = 3'd7
  } c1_cmd_e;

  // The cache answers with the same code as WRITE32, so it cannot live in the enum.
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = 4'd7;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_TS  = 3'd1,
    ST_SEND_OFF = 3'd2,
    ST_WAIT     = 3'd3,
    ST_READ_HI  = 3'd4,
    ST_DONE     = 3'd5
  } port_state_e;

  function automatic logic c1_is_write(input c1_cmd_e cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_cache_port_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : cpu_cache_port_if
// Brief     : Single-request command/response handshake into cpu_cache_port.
// Rev       : 1.0  initial release
// ============================================================================
interface cpu_cache_port_if;
  import cache_bus_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic [CPU_CMD_SIZE-1:0]  req_cmd;
  logic [CPU_ADDR_SIZE-1:0] req_addr;
  logic [CPU_DATA_SIZE-1:0] req_wdata;
  logic                     resp_valid;
  logic                     resp_err;
  logic [CPU_DATA_SIZE-1:0] resp_rdata;
  logic [15:0]              resp_latency;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, resp_latency
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata, resp_latency
  );

endinterface
`default_nettype wire

// File: rtl/cpu_cache_port_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cpu_cache_port_watchdog
// Brief  : Counts response-wait cycles; expire marks the TIMEOUT_CYCLES-th one.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_cache_port_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_start,
  input  wire logic i_enable,
  input  wire logic i_clear,
  output logic      o_expire
);

  localparam int                  c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_start || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_last)) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign o_expire = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/cpu_cache_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cpu_cache_port
// Brief  : CPU-side master that turns one valid/ready request into a C1 bus
//          transaction, with response watchdog and latency measurement.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_cache_port #(
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA1_BUS_SIZE    = 16,
  parameter int CTR1_BUS_SIZE     = 4,
  parameter int CACHE_OFFSET_SIZE = 5,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  cpu_cache_port_if.slave            cpu,
  output logic [ADDR1_BUS_SIZE-1:0]  A1,
  inout  wire  [DATA1_BUS_SIZE-1:0]  D1,
  inout  wire  [CTR1_BUS_SIZE-1:0]   C1
);
  import cache_bus_pkg::*;

  port_state_e                   r_state;
  c1_cmd_e                       r_cmd;
  logic [CACHE_OFFSET_SIZE-1:0]  r_offset;
  logic [DATA1_BUS_SIZE-1:0]     r_wdata_hi;
  logic [ADDR1_BUS_SIZE-1:0]     r_a1;
  logic [DATA1_BUS_SIZE-1:0]     r_d1;
  logic [CTR1_BUS_SIZE-1:0]      r_c1;
  logic                          r_drive;
  logic                          r_turn;
  logic                          r_err;
  logic [31:0]                   r_buf;
  logic [15:0]                   r_lat;
  logic                          r_ready;
  logic                          r_resp_valid;
  logic                          r_resp_err;
  logic [31:0]                   r_resp_rdata;
  logic [15:0]                   r_resp_lat;

  logic    w_accept;
  logic    w_resp_seen;
  logic    w_expire;
  c1_cmd_e w_req_cmd;

  assign w_req_cmd   = c1_cmd_e'(cpu.req_cmd);
  assign w_accept    = cpu.req_valid && r_ready;
  assign w_resp_seen = (C1 == C1_RESPONSE);

  cpu_cache_port_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_start  (r_state == ST_SEND_OFF),
    .i_enable (r_state == ST_WAIT),
    .i_clear  (r_state == ST_IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cmd        <= C1_NOP;
      r_offset     <= '0;
      r_wdata_hi   <= '0;
      r_a1         <= '0;
      r_d1         <= '0;
      r_c1         <= '0;
      r_drive      <= 1'b0;
      r_turn       <= 1'b0;
      r_err        <= 1'b0;
      r_buf        <= '0;
      r_lat        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_lat   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      // Latency saturates instead of wrapping on pathological timeouts.
      if ((r_state != ST_IDLE) && (r_state != ST_DONE) && (r_lat != 16'hFFFF)) begin
        r_lat <= r_lat + 16'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_cmd      <= w_req_cmd;
            r_offset   <= cpu.req_addr[CACHE_OFFSET_SIZE-1:0];
            r_wdata_hi <= cpu.req_wdata[31:16];
            r_lat      <= 16'd1;
            if (w_req_cmd == C1_NOP) begin
              r_err   <= 1'b1;
              r_buf   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_a1    <= cpu.req_addr[CACHE_OFFSET_SIZE +: ADDR1_BUS_SIZE];
              r_c1    <= CTR1_BUS_SIZE'(cpu.req_cmd);
              r_d1    <= c1_is_write(w_req_cmd) ? cpu.req_wdata[DATA1_BUS_SIZE-1:0] : '0;
              r_drive <= 1'b1;
              r_state <= ST_SEND_TS;
            end
          end
        end

        ST_SEND_TS: begin
          r_a1    <= ADDR1_BUS_SIZE'(r_offset);
          r_d1    <= (r_cmd == C1_WRITE32) ? r_wdata_hi : '0;
          r_state <= ST_SEND_OFF;
        end

        ST_SEND_OFF: begin
          r_drive <= 1'b0;
          r_turn  <= 1'b1;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_turn <= 1'b0;
          // A response on the expiry edge takes priority over the timeout.
          if (!r_turn && w_resp_seen) begin
            r_err <= 1'b0;
            case (r_cmd)
              C1_READ8:  begin r_buf <= {24'b0, D1[7:0]};     r_state <= ST_DONE;    end
              C1_READ16: begin r_buf <= {16'b0, D1};          r_state <= ST_DONE;    end
              C1_READ32: begin r_buf <= {16'b0, D1};          r_state <= ST_READ_HI; end
              default:   begin r_buf <= '0;                   r_state <= ST_DONE;    end
            endcase
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_buf   <= '0;
            r_state <= ST_DONE;
          end
        end

        ST_READ_HI: begin
          r_buf[31:16] <= D1;
          r_state      <= ST_DONE;
        end

        ST_DONE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= r_buf;
          r_resp_lat   <= r_lat;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_drive <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign A1 = r_a1;
  assign D1 = r_drive ? r_d1 : 'z;
  assign C1 = r_drive ? r_c1 : 'z;

  assign cpu.req_ready    = r_ready;
  assign cpu.resp_valid   = r_resp_valid;
  assign cpu.resp_err     = r_resp_err;
  assign cpu.resp_rdata   = r_resp_rdata;
  assign cpu.resp_latency = r_resp_lat;

endmodule
`default_nettype wire

// File: tb/tb_cpu_cache_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_cpu_cache_port
// Brief  : Scoreboard bench with a behavioural cache responder on A1/D1/C1.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_cache_port;
  import cache_bus_pkg::*;

  localparam int T = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] A1;
  wire  [15:0] D1;
  wire  [3:0]  C1;
  logic        rsp_drv;
  logic [15:0] rsp_d1;
  logic [3:0]  rsp_c1;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpu_cache_port_if bus ();

  assign D1 = rsp_drv ? rsp_d1 : 'z;
  assign C1 = rsp_drv ? rsp_c1 : 'z;

  cpu_cache_port #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (bus),
    .A1    (A1),
    .D1    (D1),
    .C1    (C1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: accept edge, two send edges, wait edge w carries the
  // response (edge 1 is turnaround), READ32 needs one more edge, then DONE.
  function automatic exp_t model(input logic [2:0] cmd, input int w,
                                 input logic [15:0] lo, input logic [15:0] hi);
    exp_t e;
    e.err = 1'b0; e.rdata = 32'h0; e.lat = 16'h0;
    if (cmd == 3'd0) begin
      e.err = 1'b1; e.lat = 16'd1;
    end else if (w == 0 || w > T) begin
      e.err = 1'b1; e.lat = 16'(T + 3);
    end else begin
      case (cmd)
        3'd1:    e.rdata = {24'h0, lo[7:0]};
        3'd2:    e.rdata = {16'h0, lo};
        3'd3:    e.rdata = {hi, lo};
        default: e.rdata = 32'h0;
      endcase
      e.lat = 16'(w + 3 + ((cmd == 3'd3) ? 1 : 0));
    end
    return e;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_err",     32'(bus.resp_err),     32'(e.err));
          check("resp_rdata",   bus.resp_rdata,        e.rdata);
          check("resp_latency", 32'(bus.resp_latency), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready(output logic ok);
    int guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (bus.req_ready === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_wait: got req_ready=%b expected 1 within 100 cycles", bus.req_ready);
    end
  endtask

  // w = wait edge carrying C1_RESPONSE (>=2); 0 = silent responder.
  task automatic do_txn(input logic [2:0] cmd, input logic [19:0] addr, input logic [31:0] wd,
                        input int w, input logic [15:0] lo, input logic [15:0] hi);
    logic ok;
    logic wr;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    q.push_back(model(cmd, w, lo, hi));
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ready_busy", 32'(bus.req_ready), 32'(1'b0));
    if (cmd == 3'd0) return;
    wr = (cmd >= 3'd5);
    check("ts_A1", 32'(A1), 32'(addr[19:5]));
    check("ts_C1", 32'(C1), 32'({1'b0, cmd}));
    check("ts_D1", 32'(D1), wr ? 32'(wd[15:0]) : 32'h0);
    @(negedge clk);
    check("off_A1", 32'(A1), 32'(addr[4:0]));
    check("off_C1", 32'(C1), 32'({1'b0, cmd}));
    check("off_D1", 32'(D1), (cmd == 3'd7) ? 32'(wd[31:16]) : 32'h0);
    @(negedge clk);
    check("wait_A1", 32'(A1), 32'(addr[4:0]));
    for (int k = 2; k <= T; k++) begin
      @(negedge clk);
      rsp_drv = 1'b1;
      if (k == w) begin
        rsp_c1 = C1_RESPONSE;
        rsp_d1 = lo;
      end else begin
        rsp_c1 = 4'd0;
        rsp_d1 = 16'($urandom);
      end
      if (k == 2) begin
        #1;
        check("release_C1", 32'(C1), 32'(rsp_c1));
        check("release_D1", 32'(D1), 32'(rsp_d1));
      end
      if (k == w) begin
        if (cmd == 3'd3) begin
          @(negedge clk);
          rsp_c1 = 4'd0;
          rsp_d1 = hi;
        end
        break;
      end
    end
    @(negedge clk);
    rsp_drv = 1'b0;
  endtask

  initial begin : stimulus
    logic        ok;
    logic [2:0]  cmd;
    int          w;
    int          sel;
    reset         = 1'b0;
    rsp_drv       = 1'b0;
    rsp_d1        = '0;
    rsp_c1        = '0;
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",      32'(bus.req_ready),    32'(1'b1));
    check("rst_resp_valid", 32'(bus.resp_valid),   32'(1'b0));
    check("rst_resp_err",   32'(bus.resp_err),     32'(1'b0));
    check("rst_resp_rdata", bus.resp_rdata,        32'h0);
    check("rst_resp_lat",   32'(bus.resp_latency), 32'h0);
    check("rst_A1",         32'(A1),               32'h0);
    reset = 1'b1;
    @(negedge clk);

    do_txn(C1_WRITE32, 20'h00000, 32'h0000_0001, 2, 16'h0, 16'h0);
    do_txn(C1_WRITE32, 20'h00200, 32'hDEAD_BEEF, 3, 16'h0, 16'h0);
    do_txn(C1_WRITE32, 20'h00400, 32'h1234_5678, 2, 16'h0, 16'h0);
    do_txn(C1_READ32,  20'h00000, 32'h0,         4, 16'h0001, 16'h0000);
    do_txn(C1_READ8,   20'h00003, 32'h0,         2, 16'hABCD, 16'h0);
    do_txn(C1_READ16,  20'h00003, 32'h0,         2, 16'hABCD, 16'h0);
    do_txn(C1_READ16,  20'h1F0A5, 32'h0,         0, 16'h0, 16'h0);
    do_txn(C1_READ32,  20'h3C01F, 32'h0,         T, 16'h5A5A, 16'hC3C3);
    do_txn(C1_READ8,   20'h0001E, 32'h0,         T + 1, 16'h1111, 16'h0);
    do_txn(C1_INVALIDATE_LINE, 20'h7FFE0, 32'h0, 5, 16'hFFFF, 16'h0);
    do_txn(C1_WRITE8,  20'hFFFFF, 32'hFFFF_00A5, 2, 16'h0, 16'h0);
    do_txn(C1_NOP,     20'h12345, 32'h0,         2, 16'h0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      cmd = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      w   = (sel == 0) ? 0 : (sel == 1) ? T : (sel == 2) ? T + 1 : $urandom_range(2, 8);
      do_txn(cmd, 20'($urandom), $urandom, w, 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while a request is stranded in WAIT: it must vanish without a response.
    wait_ready(ok);
    if (ok) begin
      bus.req_valid = 1'b1;
      bus.req_cmd   = C1_READ16;
      bus.req_addr  = 20'h0ABCD;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_ready",      32'(bus.req_ready),  32'(1'b1));
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'(1'b0));
      check("midrst_A1",         32'(A1),             32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("postrst_no_resp", 32'(bus.resp_valid), 32'(1'b0));
      end
      do_txn(C1_NOP, 20'h0, 32'h0, 2, 16'h0, 16'h0);
      do_txn(C1_READ16, 20'h00042, 32'h0, 3, 16'hBEEF, 16'h0);
    end

    for (int g = 0; g < 60 && q.size() != 0; g++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d outstanding responses expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
